// File: rtl/riscv_pkg.sv
// Shared types and constants for the Primitive RISC-V core front end.
// Fetch FSM states, buffer entry layout, opcode map and PC helpers.
package riscv_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  function automatic logic [XLEN-1:0] pc_plus4(input logic [XLEN-1:0] pc);
    return pc + 32'd4;
  endfunction

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO for fetched {pc, instr} entries; head is combinational, one-cycle write-to-read.
// Push while full is accepted only alongside a pop; flush wins over push.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [CW-1:0]    cnt;
  logic             do_push;
  logic             do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == CW'(DEPTH));
  assign count   = cnt;
  assign rdata   = mem[rptr];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset: entries are only observed once counted in.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, issues word reads, buffers responses for decode (first instr 3 cycles after reset).
// Requests stall once outstanding + buffered reach FIFO_DEPTH, so a stalled decode never overflows the buffer.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [ILEN-1:0] imem_rdata,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [ILEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  output logic [XLEN-1:0] instr_pc_plus4
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(FIFO_DEPTH);

  fetch_state_t    state;
  fetch_state_t    state_nxt;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] resp_pc;
  logic [XLEN-1:0] redirect_tgt;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   out_after_rsp;
  logic [CW-1:0]   fifo_count;
  logic [CW:0]     inflight;
  logic            rsp_ok;
  logic            redir_take;
  logic            issue;
  logic            fifo_push;
  logic            fifo_pop;
  logic            fifo_flush;
  logic            fifo_full;
  logic            fifo_empty;
  fetch_entry_t    push_ent;
  fetch_entry_t    head;
  logic            unused_lsb;

  assign unused_lsb    = ^redirect_pc[1:0];
  assign redirect_tgt  = word_align(redirect_pc);
  // Responses with nothing outstanding are orphans and must not disturb state.
  assign rsp_ok        = imem_rvalid && (outstanding != '0);
  assign out_after_rsp = outstanding - CW'(rsp_ok);
  assign redir_take    = redirect && (state != BOOT);
  assign inflight      = {1'b0, outstanding} + {1'b0, fifo_count};
  assign issue         = imem_req && imem_gnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= BOOT;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      BOOT:       state_nxt = RUN;
      RUN, DRAIN: begin
        if (redir_take)               state_nxt = (out_after_rsp != '0) ? DRAIN : RUN;
        else if (state == DRAIN && out_after_rsp == '0) state_nxt = RUN;
      end
      default:    state_nxt = BOOT;
    endcase
  end

  always_comb begin
    imem_req   = 1'b0;
    fifo_push  = 1'b0;
    fifo_flush = 1'b0;
    unique case (state)
      RUN: begin
        imem_req   = !redirect && (inflight < DEPTH_W);
        fifo_push  = rsp_ok && !redirect;
        fifo_flush = redirect;
      end
      DRAIN:   fifo_flush = redirect;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
    end else begin
      outstanding <= outstanding + CW'(issue) - CW'(rsp_ok);
      if (redir_take) begin
        fetch_pc <= redirect_tgt;
        resp_pc  <= redirect_tgt;
      end else begin
        if (issue)     fetch_pc <= pc_plus4(fetch_pc);
        if (fifo_push) resp_pc  <= pc_plus4(resp_pc);
      end
    end
  end

  assign push_ent = '{pc: resp_pc, instr: imem_rdata};
  assign fifo_pop = instr_valid && instr_ready;

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(fetch_entry_t))
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (fifo_flush),
    .wdata (push_ent),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign imem_addr      = fetch_pc;
  assign instr_valid    = !fifo_empty;
  assign instr          = instr_valid ? head.instr : '0;
  assign instr_pc       = instr_valid ? head.pc : '0;
  assign instr_pc_plus4 = instr_valid ? pc_plus4(head.pc) : '0;

  a_no_orphan_rsp: assert property (@(posedge clk) disable iff (reset)
    !(imem_rvalid && outstanding == '0));
  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(fifo_push && fifo_full && !fifo_pop));

endmodule
